// File: rtl/mskaes_128bits_inv_round_ctrl_pkg.sv
// Shared constants, controller state encoding and GF(2^8) helpers for the
// masked AES-128 inverse-round datapath and its controller.
package mskaes_128bits_inv_round_ctrl_pkg;

    localparam logic [7:0] RCON_LAST   = 8'h36;
    localparam logic [3:0] ROUNDS      = 4'd10;
    localparam int unsigned RND_STATE_W = 128;
    localparam int unsigned RND_KEY_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } ctrl_state_t;

    // Fresh randomness per cycle: one 128-bit state mask and one 32-bit
    // key-word mask for every share beyond share 0.
    function automatic int unsigned rnd_width(input int unsigned shares);
        return (shares > 1) ? (RND_STATE_W + RND_KEY_W) * (shares - 1) : 1;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned k);
        return (x << k) | (x >> (8 - k));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    // Byte (col c, row r) sits at bits [127-8*(4c+r) -: 8]; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    // Step rcon backwards through the key schedule (division by x in GF(2^8)).
    function automatic logic [7:0] inv_xtime_rcon(input logic [7:0] r);
        return r[0] ? (((r ^ 8'h1B) >> 1) | 8'h80) : (r >> 1);
    endfunction

endpackage

// File: rtl/mskaes_128bits_inv_round.sv
// One masked AES-128 inverse round (AK, optional InvMixColumns, InvShiftRows,
// InvSubBytes) plus the inverse key-schedule step, with one register stage.
module mskaes_128bits_inv_round
    import mskaes_128bits_inv_round_ctrl_pkg::*;
#(
    parameter int unsigned d     = 2,
    parameter int unsigned RND_W = rnd_width(d)
) (
    input  logic               clk,
    input  logic [128*d-1:0]   sh_state_in,
    input  logic [128*d-1:0]   sh_key_in,
    input  logic [8*d-1:0]     sh_RCON,
    input  logic               first_round,
    input  logic               cleaning_on,
    input  logic [RND_W-1:0]   rnd,
    output logic [128*d-1:0]   sh_state_out,
    output logic [128*d-1:0]   sh_key_out
);

    localparam int unsigned RS = RND_STATE_W + RND_KEY_W;

    logic [128*d-1:0] st_nxt;
    logic [128*d-1:0] key_nxt;
    logic [128*d-1:0] state_q;
    logic [128*d-1:0] key_q;
    logic [127:0]     s;
    logic [127:0]     k;
    logic [7:0]       rc;
    logic [31:0]      w0, w1, w2, w3;
    logic [127:0]     st_u;
    logic [31:0]      rot_u;
    logic [127:0]     sb;
    logic [31:0]      sw;
    logic [127:0]     m_s;
    logic [31:0]      m_k;

    // Linear layers share-wise; S-boxes on the joined byte followed by an
    // immediate remask with fresh randomness. Inputs are zeroed while cleaning.
    always_comb begin
        s       = '0;
        k       = '0;
        rc      = '0;
        w0      = '0;
        w1      = '0;
        w2      = '0;
        w3      = '0;
        st_u    = '0;
        rot_u   = '0;
        m_s     = '0;
        m_k     = '0;
        key_nxt = '0;
        st_nxt  = '0;
        for (int unsigned j = 0; j < d; j++) begin
            s  = cleaning_on ? '0 : sh_state_in[128*j +: 128];
            k  = cleaning_on ? '0 : sh_key_in[128*j +: 128];
            rc = cleaning_on ? '0 : sh_RCON[8*j +: 8];
            s  = s ^ k;
            if (!first_round) begin
                for (int unsigned c = 0; c < 4; c++) begin
                    s[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
                end
            end
            s    = inv_shift_rows(s);
            st_u = st_u ^ s;
            w3   = k[31:0]   ^ k[63:32];
            w2   = k[63:32]  ^ k[95:64];
            w1   = k[95:64]  ^ k[127:96];
            w0   = k[127:96] ^ {rc, 24'h0};
            key_nxt[128*j +: 128] = {w0, w1, w2, w3};
            rot_u = rot_u ^ {w3[23:0], w3[31:24]};
        end
        sb = '0;
        for (int unsigned b = 0; b < 16; b++) begin
            sb[8*b +: 8] = inv_sbox(st_u[8*b +: 8]);
        end
        sw = {sbox(rot_u[31:24]), sbox(rot_u[23:16]), sbox(rot_u[15:8]), sbox(rot_u[7:0])};
        for (int unsigned j = 1; j < d; j++) begin
            st_nxt[128*j +: 128]       = rnd[RS*(j-1) +: 128];
            key_nxt[128*j + 96 +: 32]  = key_nxt[128*j + 96 +: 32] ^ rnd[RS*(j-1) + 128 +: 32];
            m_s = m_s ^ rnd[RS*(j-1) +: 128];
            m_k = m_k ^ rnd[RS*(j-1) + 128 +: 32];
        end
        st_nxt[127:0]    = sb ^ m_s;
        key_nxt[127:96]  = key_nxt[127:96] ^ sw ^ m_k;
    end

    // Result register loads only on the launch cycle and holds otherwise.
    always_ff @(posedge clk) begin
        if (!cleaning_on) begin
            state_q <= st_nxt;
            key_q   <= key_nxt;
        end
    end

    assign sh_state_out = state_q;
    assign sh_key_out   = key_q;

endmodule

// File: rtl/mskaes_128bits_inv_round_ctrl.sv
// Controller for masked AES-128 decryption: runs ten inverse rounds through
// the round sub-module, then applies the final key addition share-wise.
module mskaes_128bits_inv_round_ctrl
    import mskaes_128bits_inv_round_ctrl_pkg::*;
#(
    parameter int unsigned d       = 2,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned RND_W   = rnd_width(d)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [128*d-1:0]   sh_ct_in,
    input  logic [128*d-1:0]   sh_key_in,
    input  logic [RND_W-1:0]   rnd_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [128*d-1:0]   sh_pt_out,
    output logic               busy
);

    localparam int unsigned PW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(LATENCY - 1);

    ctrl_state_t      fsm_q, fsm_n;
    logic [128*d-1:0] st_q, st_n;
    logic [128*d-1:0] key_q, key_n;
    logic [128*d-1:0] pt_q, pt_n;
    logic [3:0]       rcnt_q, rcnt_n;
    logic [PW-1:0]    phase_q, phase_n;
    logic [7:0]       rcon_q, rcon_n;
    logic [8*d-1:0]   sh_rcon;
    logic [128*d-1:0] sub_st;
    logic [128*d-1:0] sub_key;
    logic             cleaning_on;
    logic             first_round;

    mskaes_128bits_inv_round #(
        .d     (d),
        .RND_W (RND_W)
    ) u_round (
        .clk          (clk),
        .sh_state_in  (st_q),
        .sh_key_in    (key_q),
        .sh_RCON      (sh_rcon),
        .first_round  (first_round),
        .cleaning_on  (cleaning_on),
        .rnd          (rnd_in),
        .sh_state_out (sub_st),
        .sh_key_out   (sub_key)
    );

    // Sub-module control and handshake outputs decoded from registered state only.
    always_comb begin
        sh_rcon      = '0;
        sh_rcon[7:0] = rcon_q;
        first_round  = (rcnt_q == ROUNDS);
        cleaning_on  = !(rst_n && fsm_q == ST_ROUND && phase_q == '0);
        in_ready     = rst_n && (fsm_q == ST_IDLE);
        busy         = (fsm_q != ST_IDLE);
        out_valid    = (fsm_q == ST_DONE);
        sh_pt_out    = pt_q;
    end

    // Next-state and datapath update.
    always_comb begin
        fsm_n   = fsm_q;
        st_n    = st_q;
        key_n   = key_q;
        pt_n    = pt_q;
        rcnt_n  = rcnt_q;
        phase_n = phase_q;
        rcon_n  = rcon_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    st_n    = sh_ct_in;
                    key_n   = sh_key_in;
                    rcnt_n  = ROUNDS;
                    phase_n = '0;
                    rcon_n  = RCON_LAST;
                    fsm_n   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (phase_q == PH_LAST) begin
                    phase_n = '0;
                    st_n    = sub_st;
                    key_n   = sub_key;
                    rcnt_n  = rcnt_q - 4'd1;
                    rcon_n  = inv_xtime_rcon(rcon_q);
                    if (rcnt_q == 4'd1) begin
                        pt_n  = sub_st ^ sub_key;
                        fsm_n = ST_DONE;
                    end
                end else begin
                    phase_n = phase_q + PW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    st_n  = '0;
                    key_n = '0;
                    pt_n  = '0;
                    fsm_n = ST_IDLE;
                end
            end
            default: fsm_n = ST_IDLE;
        endcase
    end

    // State register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            st_q    <= '0;
            key_q   <= '0;
            pt_q    <= '0;
            rcnt_q  <= '0;
            phase_q <= '0;
            rcon_q  <= '0;
        end else begin
            fsm_q   <= fsm_n;
            st_q    <= st_n;
            key_q   <= key_n;
            pt_q    <= pt_n;
            rcnt_q  <= rcnt_n;
            phase_q <= phase_n;
            rcon_q  <= rcon_n;
        end
    end

endmodule

// File: tb/tb_mskaes_128bits_inv_round_ctrl.sv
// Bench for the masked AES-128 inverse-round controller (d = 2, LATENCY = 4).
module tb_mskaes_128bits_inv_round_ctrl;

    localparam int unsigned D    = 2;
    localparam int unsigned LAT  = 4;
    localparam int unsigned RW   = 160 * (D - 1);

    typedef struct {
        logic [127:0] ct;
        logic [127:0] key;
        logic [127:0] pt;
        int unsigned  hold;
        bit           noise;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [128*D-1:0]   sh_ct_in;
    logic [128*D-1:0]   sh_key_in;
    logic [RW-1:0]      rnd_in;
    logic               out_valid;
    logic               out_ready;
    logic [128*D-1:0]   sh_pt_out;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int hs_cnt = 0;
    int acc_cyc = 0;
    int hs_cyc = 0;
    int clean_lo = 0;
    bit trace_on = 1'b0;
    logic [127:0] cur_exp = '0;
    logic [127:0] exp_q[$];
    logic [7:0]   rcon_seen[$];

    mskaes_128bits_inv_round_ctrl #(
        .d       (D),
        .LATENCY (LAT),
        .RND_W   (RW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sh_ct_in  (sh_ct_in),
        .sh_key_in (sh_key_in),
        .rnd_in    (rnd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sh_pt_out (sh_pt_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Fresh randomness every cycle, changed away from the clock edge.
    always begin
        @(posedge clk);
        #2;
        for (int i = 0; i < RW / 32; i++) rnd_in[32*i +: 32] = $urandom;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] recomb(input logic [128*D-1:0] x);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < D; j++) r = r ^ x[128*j +: 128];
        return r;
    endfunction

    function automatic logic [128*D-1:0] split(input logic [127:0] x);
        logic [128*D-1:0] r;
        logic [127:0] acc;
        logic [127:0] m;
        r   = '0;
        acc = x;
        for (int j = 1; j < D; j++) begin
            m = {$urandom, $urandom, $urandom, $urandom};
            r[128*j +: 128] = m;
            acc = acc ^ m;
        end
        r[127:0] = acc;
        return r;
    endfunction

    // Scoreboard: push on accepted input, pop and compare on output handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
                acc_cnt++;
                acc_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                hs_cyc = cyc;
                if (exp_q.size() == 0) chk("sb_unexpected_output", 128'd1, 128'd0);
                else chk("sb_pt", recomb(sh_pt_out), exp_q.pop_front());
            end
            if (trace_on) begin
                if (!dut.cleaning_on) clean_lo++;
                if (busy && !out_valid && dut.phase_q == 2'(LAT - 1)) rcon_seen.push_back(dut.rcon_q);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int n;
        bit got;
        bit rdy_bad;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("idle_ready", in_ready, 1'b1);
        cur_exp   = v.pt;
        sh_ct_in  = split(v.ct);
        sh_key_in = split(v.key);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0; got = 0; rdy_bad = 0;
        while (n < 200) begin
            @(posedge clk); #1; n++;
            if (out_valid) begin got = 1; break; end
            if (in_ready || !busy) rdy_bad = 1;
            if (v.noise && (n % 5 == 2)) begin
                in_valid = 1'b1;
                sh_ct_in = split({$urandom, $urandom, $urandom, $urandom});
                sh_key_in = split({$urandom, $urandom, $urandom, $urandom});
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        if (!got) chk("timeout_out_valid", 128'd0, 128'd1);
        chk("latency", 128'(n), 128'(10 * LAT));
        chk("ready_low_while_busy", 128'(rdy_bad), 128'd0);
        for (int h = 0; h < int'(v.hold); h++) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_pt", recomb(sh_pt_out), v.pt);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_valid", out_valid, 1'b0);
        chk("post_ready", in_ready, 1'b1);
        chk("post_busy", busy, 1'b0);
        chk("post_pt_zero", 128'(|sh_pt_out), 128'd0);
    endtask

    vec_t vecs[4];
    logic [7:0] rc_exp[10];

    initial begin
        int n;
        int hbase;
        int abase;
        vec_t c1;
        vec_t fb;
        c1 = '{ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, key: 128'h13111d7fe3944a17f307a78b4d2b30c5,
               pt: 128'h00112233445566778899aabbccddeeff, hold: 0, noise: 1'b0};
        fb = '{ct: 128'h3925841d02dc09fbdc118597196a0b32, key: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
               pt: 128'h3243f6a8885a308d313198a2e0370734, hold: 0, noise: 1'b0};
        vecs[0] = c1;
        vecs[1] = c1; vecs[1].hold = 7;
        vecs[2] = fb; vecs[2].noise = 1'b1;
        vecs[3] = fb; vecs[3].hold = 3; vecs[3].noise = 1'b1;
        rc_exp = '{8'h36, 8'h1B, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sh_ct_in = '0; sh_key_in = '0; rnd_in = '0;
        #1;
        chk("rst_in_ready_low", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_pt", 128'(|sh_pt_out), 128'd0);
        chk("rst_cleaning", dut.cleaning_on, 1'b1);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // Table-driven runs; first one also traces rcon and launch cycles.
        for (int i = 0; i < 4; i++) begin
            trace_on = (i == 0);
            run_vec(vecs[i]);
            if (i == 0) begin
                trace_on = 1'b0;
                chk("rcon_count", 128'(rcon_seen.size()), 128'd10);
                for (int r = 0; r < 10 && r < rcon_seen.size(); r++)
                    chk($sformatf("rcon_%0d", r), rcon_seen[r], rc_exp[r]);
                chk("launch_cycles", 128'(clean_lo), 128'd10);
            end
        end

        // Reset in the middle of a run.
        cur_exp = c1.pt;
        sh_ct_in = split(c1.ct);
        sh_key_in = split(c1.key);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready_low", in_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        exp_q.delete();
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_ready", in_ready, 1'b1);
        chk("midrst_state", recomb(dut.st_q), 128'd0);
        chk("midrst_key", recomb(dut.key_q), 128'd0);
        chk("midrst_rcon", dut.rcon_q, 8'h00);
        run_vec(c1);

        // Back-to-back with in_valid and out_ready held high.
        hbase = hs_cnt; abase = acc_cnt;
        cur_exp = c1.pt;
        sh_ct_in = split(c1.ct);
        sh_key_in = split(c1.key);
        in_valid = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (hs_cnt < hbase + 2 && n < 300) begin
            @(posedge clk); #1; n++;
            if (acc_cnt == abase + 1 && cur_exp != fb.pt) begin
                cur_exp = fb.pt;
                sh_ct_in = split(fb.ct);
                sh_key_in = split(fb.key);
            end
            if (acc_cnt >= abase + 2 && in_valid) begin
                in_valid = 1'b0;
                chk("b2b_gap", 128'(acc_cyc - hs_cyc), 128'd1);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        if (n >= 300) chk("timeout_b2b", 128'd0, 128'd1);
        chk("b2b_accepts", 128'(acc_cnt - abase), 128'd2);
        chk("sb_drained", 128'(exp_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mskaes_128bits_inv_round_ctrl.md
MSKAES_128BITS_INV_ROUND_CTRL -- requirements
Module: MSKaes_128bits_inv_round_ctrl

Interface
REQ-001 SHALL have parameter d, default 2, number of shares.
REQ-002 SHALL have parameter LATENCY, default 4, cycles from sub-module launch to valid round output.
REQ-003 SHALL have parameter RND_W, default per design.vh, fresh-randomness bits per cycle.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  ciphertext/key presented.
REQ-007 in_ready  out  1  high iff FSM in IDLE.
REQ-008 sh_ct_in  in  128*d  shared ciphertext.
REQ-009 sh_key_in  in  128*d  shared last round key K10.
REQ-010 rnd_in  in  RND_W  fresh randomness, new value every cycle.
REQ-011 out_valid  out  1  plaintext available.
REQ-012 out_ready  in  1  consumer accepts plaintext.
REQ-013 sh_pt_out  out  128*d  shared plaintext, registered.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, ROUND, DONE.
REQ-016 IDLE: on in_valid && in_ready, state reg <= sh_ct_in, key reg <= sh_key_in, rcnt <= 10, phase <= 0, rcon <= 0x36, go ROUND.
REQ-017 Per inverse round r=10..1 sub-module computes AK(K_r), InvMixColumns (bypassed when r=10), InvShiftRows, InvSubBytes, and inverse key step K_r -> K_(r-1) using rcon.
REQ-018 ROUND: phase counts 0..LATENCY-1; phase 0 is launch cycle with cleaning_on=0; all other ROUND cycles and all IDLE/DONE cycles drive cleaning_on=1.
REQ-019 At phase LATENCY-1 edge: state and key regs capture sub-module outputs, rcnt decrements, rcon <= inverse-xtime(rcon): lsb=1 -> ((rcon^0x1B)>>1)|0x80, else rcon>>1; phase wraps to 0.
REQ-020 Capture with rcnt=1 SHALL load sh_pt_out <= state_next XOR key_next (final AK with K0, share-wise) and go DONE.
REQ-021 rcon masking: share 0 = rcon, shares 1..d-1 = 0.
REQ-022 DONE: out_valid=1; hold sh_pt_out stable until out_valid && out_ready; that edge clears state, key and sh_pt_out regs to 0 and goes IDLE.
REQ-023 Handshake at edge E0 -> out_valid high after edge E0+10*LATENCY (40 cycles for LATENCY=4).
REQ-024 in_valid ignored while busy; out_ready ignored outside DONE.
REQ-025 No combinational path in_valid->in_ready or out_ready->out_valid.
REQ-026 rnd_in forwarded unregistered to sub-module every cycle.

Reset
REQ-027 rst_n=0 at an edge SHALL, regardless of state (incl. mid-round): FSM <= IDLE, state/key/sh_pt_out regs <= 0, rcnt, phase, rcon <= 0.
REQ-028 During and after reset until next handshake: out_valid=0, busy=0, in_ready=1 (0 while rst_n=0), cleaning_on=1.

Structure
REQ-029 Shared package/header (design.vh) SHALL hold rnd bus widths, RCON_LAST=0x36, ROUNDS=10, FSM state encodings.
REQ-030 One sub-module: MSKaes_128bits_inv_round (masked inverse round + inverse key step, ports clk, sh_state_in, sh_key_in, sh_RCON, first_round, cleaning_on, rnd, sh_state_out, sh_key_out).
REQ-031 No unmasked intermediate value SHALL exist in the controller; all 128*d datapaths stay share-wise.

Verification (shares recombined by XOR in bench)
REQ-032 FIPS-197 C.1: ct 69c4e0d86a7b0430d8cdb78070b4c55a, K10 13111d7fe3944a17f307a78b4d2b30c5 -> pt 00112233445566778899aabbccddeeff, out_valid after exactly 40 cycles.
REQ-033 Same vector with random share splits, out_ready low 7 cycles -> sh_pt_out recombination constant, out_valid held, then IDLE next cycle.
REQ-034 in_valid pulses with other data during ROUND -> ignored; result unchanged; in_ready=0 throughout.
REQ-035 rst_n=0 at cycle 17 of a run -> next cycle IDLE, out_valid=0, regs 0; fresh run then produces correct pt.
REQ-036 Trace rcon at each capture -> 36,1B,80,40,20,10,08,04,02,01; cleaning_on=0 only on phase-0 cycles (10 per run).
REQ-037 Back-to-back: in_valid held high, out_ready held high -> second accept one cycle after first DONE handshake, both results correct.
